// File: rtl/score4_turn_ctrl.sv
// Score-4 turn controller: button edge detection, per-player column cursors,
// board occupancy/ownership/height state and the PLAY/CHECK/OVER turn FSM.
// Optional feature: define SCORE4_CURSOR_WRAP_EN to make the cursor wrap at
// the column ends; by default it saturates.
module score4_turn_ctrl #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned COLS        = 7,
    parameter int unsigned ROWS        = 6,
    localparam int unsigned PW = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int unsigned CW = $clog2(COLS),
    localparam int unsigned RW = $clog2(ROWS + 1),
    localparam int unsigned NC = COLS * ROWS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   left,
    input  logic                   right,
    input  logic                   put,
    input  logic                   win_in,
    output logic [PW-1:0]          player,
    output logic [CW-1:0]          cursor,
    output logic                   place_valid,
    output logic [CW-1:0]          place_col,
    output logic [RW-1:0]          place_row,
    output logic [NC-1:0]          occupancy,
    output logic [NC*PW-1:0]       owner,
    output logic                   invalid_move,
    output logic [NUM_PLAYERS-1:0] win,
    output logic                   full_panel,
    output logic                   game_over
);

    localparam int unsigned TW = $clog2(NC + 1);

    typedef enum logic [1:0] {StPlay, StCheck, StOver} state_e;

    state_e        state_q;
    logic          left_prev_q, right_prev_q, put_prev_q;
    logic [CW-1:0] cursor_q [NUM_PLAYERS];
    logic [RW-1:0] height_q [COLS];
    logic [TW-1:0] token_count_q;

    logic          left_edge, right_edge, put_edge;
    logic [RW-1:0] cur_height;
    logic          col_full;
    logic [CW-1:0] cursor_inc, cursor_dec;
    int            cell_idx;

    // Rising-edge detection on the already-synchronised button levels
    always_comb begin
        left_edge  = left & ~left_prev_q;
        right_edge = right & ~right_prev_q;
        put_edge   = put & ~put_prev_q;
    end

    // Active cursor, the height of its column and the next cursor positions
    always_comb begin
        cursor = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (PW'(p) == player) cursor = cursor_q[p];
        end
        cur_height = '0;
        for (int c = 0; c < COLS; c++) begin
            if (CW'(c) == cursor) cur_height = height_q[c];
        end
        col_full = (cur_height == RW'(ROWS));
        cell_idx = int'(cur_height) * int'(COLS) + int'(cursor);
`ifdef SCORE4_CURSOR_WRAP_EN
        cursor_inc = (cursor == CW'(COLS - 1)) ? '0 : cursor + 1'b1;
        cursor_dec = (cursor == '0) ? CW'(COLS - 1) : cursor - 1'b1;
`else
        cursor_inc = (cursor == CW'(COLS - 1)) ? cursor : cursor + 1'b1;
        cursor_dec = (cursor == '0) ? cursor : cursor - 1'b1;
`endif
    end

    // Turn FSM together with all board state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StPlay;
            left_prev_q   <= 1'b0;
            right_prev_q  <= 1'b0;
            put_prev_q    <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) cursor_q[p] <= CW'(COLS / 2);
            for (int c = 0; c < COLS; c++) height_q[c] <= '0;
            token_count_q <= '0;
            player        <= '0;
            place_valid   <= 1'b0;
            place_col     <= '0;
            place_row     <= '0;
            occupancy     <= '0;
            owner         <= '0;
            invalid_move  <= 1'b0;
            win           <= '0;
            full_panel    <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            left_prev_q  <= left;
            right_prev_q <= right;
            put_prev_q   <= put;
            place_valid  <= 1'b0;
            unique case (state_q)
                StPlay: begin
                    // put outranks right, right outranks left
                    if (put_edge) begin
                        if (col_full) begin
                            invalid_move <= 1'b1;
                        end else begin
                            for (int i = 0; i < NC; i++) begin
                                if (i == cell_idx) begin
                                    occupancy[i]        <= 1'b1;
                                    owner[i*PW +: PW]   <= player;
                                end
                            end
                            for (int c = 0; c < COLS; c++) begin
                                if (CW'(c) == cursor) height_q[c] <= cur_height + 1'b1;
                            end
                            token_count_q <= token_count_q + 1'b1;
                            place_col     <= cursor;
                            place_row     <= cur_height;
                            place_valid   <= 1'b1;
                            invalid_move  <= 1'b0;
                            state_q       <= StCheck;
                        end
                    end else if (right_edge || left_edge) begin
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            if (PW'(p) == player) begin
                                cursor_q[p] <= right_edge ? cursor_inc : cursor_dec;
                            end
                        end
                        invalid_move <= 1'b0;
                    end
                end
                StCheck: begin
                    if (win_in) begin
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            if (PW'(p) == player) win[p] <= 1'b1;
                        end
                        game_over <= 1'b1;
                        state_q   <= StOver;
                    end else if (token_count_q == TW'(NC)) begin
                        full_panel <= 1'b1;
                        game_over  <= 1'b1;
                        state_q    <= StOver;
                    end else begin
                        player  <= (player == PW'(NUM_PLAYERS - 1)) ? '0 : player + 1'b1;
                        state_q <= StPlay;
                    end
                end
                default: begin
                    // StOver: held until reset
                end
            endcase
        end
    end

endmodule
